// File: rtl/etapa_ex_muldiv.sv
// -----------------------------------------------------------------------------
// etapa_ex_muldiv
// Iterative multiply/divide unit for the EX stage. It computes one result bit
// per cycle into HI/LO. While it works, o_Busy asks the hazard unit to stall
// the front of the pipeline.
//
// Optional build macro: MULDIV_SIGNED_EN
//   defined   -> ops 10 (MULT) and 11 (DIV) use signed two's complement
//   undefined -> i_Op[1] is ignored, so 10/11 behave as 00/01
//
// Ports
//   i_clk, i_reset : clock (rising edge); reset (asynchronous, active-high)
//   i_Abort        : cancel the op in flight (EX flush); beats i_Start
//   i_Start        : valid muldiv op presented by ID/EX this cycle
//   i_Op           : 00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   i_A, i_B       : rs (multiplicand/dividend), rt (multiplier/divisor)
//   o_Busy         : combinational stall request
//   o_Done         : one-cycle pulse, HI/LO hold a new result
//   o_HI, o_LO     : product high/low word, or remainder/quotient
//   o_DivZero      : the last completed op was a divide by zero
// -----------------------------------------------------------------------------
module etapa_ex_muldiv #(
  parameter int NBITS   = 32,
  parameter int CNTBITS = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_Abort,
  input  logic             i_Start,
  input  logic [1:0]       i_Op,
  input  logic [NBITS-1:0] i_A,
  input  logic [NBITS-1:0] i_B,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [NBITS-1:0] o_HI,
  output logic [NBITS-1:0] o_LO,
  output logic             o_DivZero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nx;
  logic [CNTBITS-1:0] cnt;
  // Working register.
  //   MUL: {carry+partial high word, multiplier shifting out from bit 0}
  //   DIV: {remainder (NBITS+1), dividend shifting into quotient}
  logic [2*NBITS:0]   work, work_step;
  logic [NBITS-1:0]   opnd;        // multiplicand or divisor magnitude
  logic               op_div, neg_res, neg_rem;

  logic               sgn_a, sgn_b;
  logic [NBITS-1:0]   mag_a, mag_b;
  logic               start_ok, start_dz, last_iter;
  logic [NBITS:0]     rem_sh, mul_sum;
  logic [NBITS-1:0]   res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
  assign sgn_a = i_Op[1] & i_A[NBITS-1];
  assign sgn_b = i_Op[1] & i_B[NBITS-1];
`else
  logic op_sign_unused;
  assign op_sign_unused = i_Op[1];
  assign sgn_a = 1'b0;
  assign sgn_b = 1'b0;
`endif

  // Operands become magnitudes at Start. The sign fix-up is applied once,
  // to the final result.
  assign mag_a = sgn_a ? -i_A : i_A;
  assign mag_b = sgn_b ? -i_B : i_B;

  assign start_ok  = i_Start & ~i_Abort & (state != BUSY);
  assign start_dz  = start_ok & i_Op[0] & (i_B == '0);
  assign last_iter = (cnt == CNTBITS'(NBITS - 1));

  assign o_Busy = (state == BUSY) | i_Start;
  assign o_Done = (state == DONE);

  // One iteration of the datapath.
  always_comb begin
    // NOTE: every signal written here gets a value before any branch; otherwise
    // a path that skips the assignment would infer a latch.
    work_step = work;
    rem_sh    = work[2*NBITS-1:NBITS-1];
    mul_sum   = work[2*NBITS:NBITS] + (work[0] ? {1'b0, opnd} : '0);
    if (op_div) begin
      // Restoring division: shift in the next dividend bit, then keep the
      // difference only if it did not go negative.
      if (rem_sh >= {1'b0, opnd})
        work_step = {rem_sh - {1'b0, opnd}, work[NBITS-2:0], 1'b1};
      else
        work_step = {work[2*NBITS-1:0], 1'b0};
    end else begin
      work_step = {1'b0, mul_sum, work[NBITS-1:1]};
    end
  end

  // Final result, taken from the last iteration with the sign restored.
  always_comb begin
    res_hi = work_step[2*NBITS-1:NBITS];
    res_lo = work_step[NBITS-1:0];
    if (op_div) begin
      if (neg_res) res_lo = -work_step[NBITS-1:0];
      if (neg_rem) res_hi = -work_step[2*NBITS-1:NBITS];
    end else if (neg_res) begin
      {res_hi, res_lo} = -work_step[2*NBITS-1:0];
    end
  end

  always_comb begin
    state_nx = state;
    if (i_Abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_Start)            state_nx = start_dz ? DONE : BUSY;
          else if (state == DONE) state_nx = IDLE;
        end
        BUSY:       if (last_iter) state_nx = DONE;
        default:    state_nx = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // sees pre-edge values, whatever order the statements are written in.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      opnd      <= '0;
      op_div    <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      o_HI      <= '0;
      o_LO      <= '0;
      o_DivZero <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        cnt     <= '0;
        op_div  <= i_Op[0];
        neg_res <= sgn_a ^ sgn_b;
        neg_rem <= sgn_a;
        opnd    <= i_Op[0] ? mag_b : mag_a;
        work    <= {{(NBITS+1){1'b0}}, (i_Op[0] ? mag_a : mag_b)};
        if (start_dz) begin
          o_HI      <= i_A;
          o_LO      <= '1;
          o_DivZero <= 1'b1;
        end
      end else if (state == BUSY && !i_Abort) begin
        cnt  <= cnt + CNTBITS'(1);
        work <= work_step;
        // HI/LO change only at completion, so partial results never show.
        if (last_iter) begin
          o_HI      <= res_hi;
          o_LO      <= res_lo;
          o_DivZero <= 1'b0;
        end
      end
    end
  end

endmodule
